stage7: RTL and testbench
=========================

# stage7

Normalisation stage of the 3x3 weighted-filter pipeline. It consumes the weight sum and the weighted pixel sum produced by the nine-way summation stage and divides the pixel sum by the weight sum. It emits one rounded, saturated 8-bit output pixel per accepted pair. It is a multi-cycle, iterative restoring divider with valid/ready handshakes on both sides.

## Interface
Parameters:
- NUM_W, 16, width of the weighted pixel sum (numerator)
- DEN_W, 8, width of the weight sum (denominator)
- OUT_W, 8, output pixel width; quotients above 2^OUT_W-1 saturate
- ROUND, 1, 1 = round to nearest (add den>>1 before dividing), 0 = truncate

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- num  in  NUM_W  weighted pixel sum
- den  in  DEN_W  weight sum
- in_valid  in  1  num/den valid
- in_ready  out  1  stage can accept a pair
- pix  out  OUT_W  normalised pixel
- div_zero  out  1  result came from den == 0
- sat  out  1  quotient exceeded 2^OUT_W-1 and was clamped
- out_valid  out  1  pix/div_zero/sat valid
- out_ready  in  1  downstream accepts result

Reset is asynchronous and active-low on rst; clk is the only clock.

## Operation
- FSM states: IDLE, DIV, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture den_r=den and acc=num+(ROUND ? den>>1 : 0). acc is NUM_W+1 bits wide, so there is no overflow.
  - If den==0: go to DONE with pix=0, div_zero=1, sat=0.
  - Otherwise: go to DIV, iteration counter = NUM_W (counts NUM_W+1 iterations down to 0), remainder=0.
- DIV: one restoring step per cycle, MSB first.
  - rem={rem,acc[MSB]}, acc<<=1.
  - If rem>=den_r: rem-=den_r and the quotient bit is 1.
  - Remainder register is DEN_W+1 bits.
  - When counter==0, leave DIV for DONE.
- Entering DONE from DIV:
  - The quotient is NUM_W+1 bits.
  - If any bit at or above OUT_W is set: pix=all ones, sat=1.
  - Otherwise: pix=quotient[OUT_W-1:0], sat=0.
  - div_zero=0.
- DONE:
  - out_valid=1. pix, div_zero and sat are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE next edge.
- in_ready is low in DIV and DONE. Input is never accepted while a result is pending, and there is no bypass.
- in_valid while in_ready=0 is ignored. The upstream stage holds data until the handshake.

## Timing
- Reset values: in_ready=0, out_valid=0, pix=0, div_zero=0, sat=0, state=IDLE.
- in_ready is registered. It rises on the first clk edge after rst deasserts.
- Latency, with acceptance edge = cycle 0:
  - den!=0: out_valid high from cycle NUM_W+2 (cycle 18 at defaults).
  - den==0: out_valid high from cycle 1.
- Handshake timing: out handshake at edge k gives out_valid=0 and in_ready=1 after edge k, and a new input can be accepted at edge k+1.
- Minimum spacing between accepts is NUM_W+3 cycles when out_ready is held high (19 at defaults).
- Reset mid-DIV or mid-DONE: all state and outputs return to reset values immediately. The pending result is discarded and never presented.
- pix, div_zero and sat are registered and change only on entry to DONE or on reset.

## Structure
- Shared package/header stage_pkg holds:
  - FSM state encoding (IDLE/DIV/DONE)
  - default pipeline widths NUM_W/DEN_W/OUT_W, shared with the summation stage
- One sub-module, restoring_div_step: combinational single-iteration shift/compare/subtract, parameterised on DEN_W. stage7 owns the FSM, counter, registers and handshakes.

## Test plan
- num=1000, den=10, ROUND=1, out_ready=1 -> pix=100, sat=0, div_zero=0, out_valid first high in cycle 18.
- num=1005, den=10: ROUND=1 -> pix=101. ROUND=0 -> pix=100.
- num=65535, den=1 -> pix=255, sat=1. Also num=2550, den=10 -> pix=255, sat=0 (no false saturation).
- den=0, num=1234 -> out_valid in cycle 1, pix=0, div_zero=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> pix/flags stable, in_ready=0 throughout, in_valid pulses ignored. Release -> in_ready=1 the following cycle.
- Reset asserted in DIV iteration 7 -> outputs return to reset values asynchronously. After release, a fresh num=600, den=3 yields pix=200 with no residue from the aborted operation.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared definitions for the 3x3 weighted-filter pipeline: default datapath
// widths (common with the summation stage) and the normalisation FSM encoding.
package stage_pkg;

    localparam int DEF_NUM_W = 16;  // weighted pixel sum width
    localparam int DEF_DEN_W = 8;   // weight sum width
    localparam int DEF_OUT_W = 8;   // output pixel width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : stage_pkg

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, then subtract the divisor if it fits.
module restoring_div_step #(
    parameter int DEN_W = 8
) (
    input  logic [DEN_W:0]   i_rem,    // partial remainder, always < i_den
    input  logic             i_bit,    // next dividend bit, MSB first
    input  logic [DEN_W-1:0] i_den,    // divisor, non-zero
    output logic [DEN_W:0]   o_rem,    // updated partial remainder
    output logic             o_q_bit   // quotient bit produced by this step
);

    logic [DEN_W+1:0] w_trial;
    logic [DEN_W:0]   w_diff;

    // Since i_rem < i_den, the shifted value is below 2*i_den, so the
    // difference (when taken) always fits back into DEN_W+1 bits.
    assign w_trial = {i_rem, i_bit};
    assign o_q_bit = (w_trial >= (DEN_W+2)'(i_den));
    assign w_diff  = w_trial[DEN_W:0] - {1'b0, i_den};
    assign o_rem   = o_q_bit ? w_diff : w_trial[DEN_W:0];

endmodule : restoring_div_step

// File: rtl/stage7.sv
// Normalisation stage: divides the weighted pixel sum by the weight sum with
// an iterative restoring divider, producing one rounded, saturated pixel per
// accepted pair. Valid/ready handshakes on both sides, one result in flight.
module stage7
    import stage_pkg::*;
#(
    parameter int NUM_W = DEF_NUM_W,
    parameter int DEN_W = DEF_DEN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter bit ROUND = 1'b1
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] pix,
    output logic             div_zero,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [NUM_W:0]   r_acc;       // dividend bits shift out, quotient bits shift in
    logic [DEN_W:0]   r_rem;
    logic [DEN_W-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_pix;
    logic             r_div_zero;
    logic             r_sat;

    logic             w_accept;
    logic [NUM_W:0]   w_half;
    logic [NUM_W:0]   w_acc_init;
    logic [DEN_W:0]   w_rem_next;
    logic             w_q_bit;
    logic [NUM_W:0]   w_quot;
    logic             w_quot_sat;

    assign w_accept   = in_valid & r_in_ready;

    // Rounding bias is added once up front; the extra accumulator bit absorbs
    // the carry so the full-scale numerator cannot wrap.
    assign w_half     = ROUND ? (NUM_W+1)'(den >> 1) : '0;
    assign w_acc_init = (NUM_W+1)'(num) + w_half;

    restoring_div_step #(
        .DEN_W (DEN_W)
    ) u_step (
        .i_rem   (r_rem),
        .i_bit   (r_acc[NUM_W]),
        .i_den   (r_den),
        .o_rem   (w_rem_next),
        .o_q_bit (w_q_bit)
    );

    // On the last iteration this is the complete NUM_W+1 bit quotient.
    assign w_quot     = {r_acc[NUM_W-1:0], w_q_bit};
    assign w_quot_sat = |w_quot[NUM_W:OUT_W];

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic.
    // NOTE: the default assignment first guarantees no latch on any path through the case.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)       w_next_state = (den == '0) ? ST_DONE : ST_DIV;
            ST_DIV:  if (r_cnt == '0)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready)      w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    // Datapath, handshake flags and result registers.
    // NOTE: datapath registers are reset too so an aborted division leaves no residue behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_den       <= '0;
            r_cnt       <= '0;
            r_pix       <= '0;
            r_div_zero  <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_out_valid <= (w_next_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_den <= den;
                        r_acc <= w_acc_init;
                        r_rem <= '0;
                        r_cnt <= CNT_W'(NUM_W);
                        if (den == '0) begin
                            r_pix      <= '0;
                            r_div_zero <= 1'b1;
                            r_sat      <= 1'b0;
                        end
                    end
                end
                ST_DIV: begin
                    r_acc <= w_quot;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_pix      <= w_quot_sat ? '1 : w_quot[OUT_W-1:0];
                        r_sat      <= w_quot_sat;
                        r_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign pix       = r_pix;
    assign div_zero  = r_div_zero;
    assign sat       = r_sat;

endmodule : stage7

// File: tb/tb_stage7.sv
// Directed bench for stage7: a rounding and a truncating instance share the
// input side and out_ready; expected values are hand-computed constants.
module tb_stage7;

    logic        clk;
    logic        rst;
    logic [15:0] num;
    logic [7:0]  den;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready,   in_ready_t;
    logic [7:0]  pix,        pix_t;
    logic        div_zero,   div_zero_t;
    logic        sat,        sat_t;
    logic        out_valid,  out_valid_t;

    int n_checks = 0;
    int n_fail   = 0;

    stage7 #(.NUM_W(16), .DEN_W(8), .OUT_W(8), .ROUND(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .den       (den),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix       (pix),
        .div_zero  (div_zero),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stage7 #(.NUM_W(16), .DEN_W(8), .OUT_W(8), .ROUND(1'b0)) dut_t (
        .clk       (clk),
        .rst       (rst),
        .num       (num),
        .den       (den),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .pix       (pix_t),
        .div_zero  (div_zero_t),
        .sat       (sat_t),
        .out_valid (out_valid_t),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present one pair, return just after the accept edge.
    task automatic send(input logic [15:0] n, input logic [7:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        num      = n;
        den      = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles (accept edge = cycle 0) until out_valid is seen, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    int          lat;
    logic [7:0]  held_pix;

    initial begin
        rst       = 1'b0;
        num       = '0;
        den       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pix",       32'(pix),       32'd0);
        check("rst_div_zero",  32'(div_zero),  32'd0);
        check("rst_sat",       32'(sat),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_low_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_rises_first_edge", 32'(in_ready), 32'd1);

        // 1000/10, rounded and truncated
        send(16'd1000, 8'd10);
        wait_result(lat);
        check("lat_1000_10",  32'(lat),       32'd18);
        check("pix_1000_10",  32'(pix),       32'd100);
        check("sat_1000_10",  32'(sat),       32'd0);
        check("dz_1000_10",   32'(div_zero),  32'd0);
        check("pixt_1000_10", 32'(pix_t),     32'd100);
        check("ovt_1000_10",  32'(out_valid_t), 32'd1);

        // Rounding vs truncation
        send(16'd1005, 8'd10);
        wait_result(lat);
        check("pix_1005_10_round", 32'(pix),   32'd101);
        check("pix_1005_10_trunc", 32'(pix_t), 32'd100);

        // Saturation
        send(16'd65535, 8'd1);
        wait_result(lat);
        check("pix_65535_1",  32'(pix),   32'd255);
        check("sat_65535_1",  32'(sat),   32'd1);
        check("satt_65535_1", 32'(sat_t), 32'd1);

        // Exactly full scale, no false saturation
        send(16'd2550, 8'd10);
        wait_result(lat);
        check("pix_2550_10",  32'(pix),   32'd255);
        check("sat_2550_10",  32'(sat),   32'd0);
        check("pixt_2550_10", 32'(pix_t), 32'd255);
        check("satt_2550_10", 32'(sat_t), 32'd0);

        // Divide by zero
        send(16'd1234, 8'd0);
        wait_result(lat);
        check("lat_den0", 32'(lat),        32'd1);
        check("pix_den0", 32'(pix),        32'd0);
        check("dz_den0",  32'(div_zero),   32'd1);
        check("sat_den0", 32'(sat),        32'd0);
        check("dzt_den0", 32'(div_zero_t), 32'd1);
        @(negedge clk);
        check("ov_den0_done", 32'(out_valid), 32'd0);

        // Backpressure: result held, inputs ignored
        out_ready = 1'b0;
        send(16'd1000, 8'd10);
        wait_result(lat);
        check("bp_lat", 32'(lat), 32'd18);
        held_pix = pix;
        check("bp_pix", 32'(held_pix), 32'd100);
        for (int i = 0; i < 5; i++) begin
            num      = 16'd777;
            den      = 8'd7;
            in_valid = (i % 2 == 0);
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_pix_stable", 32'(pix),      32'd100);
            check("bp_dz_stable",  32'(div_zero), 32'd0);
            check("bp_in_ready",   32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset during DIV iteration 7, then a clean operation
        send(16'd50000, 8'd7);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_pix",       32'(pix),       32'd0);
        check("midrst_div_zero",  32'(div_zero),  32'd0);
        check("midrst_sat",       32'(sat),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(16'd600, 8'd3);
        wait_result(lat);
        check("post_rst_lat", 32'(lat),      32'd18);
        check("post_rst_pix", 32'(pix),      32'd200);
        check("post_rst_sat", 32'(sat),      32'd0);
        check("post_rst_dz",  32'(div_zero), 32'd0);
        check("post_rst_pixt", 32'(pix_t),   32'd200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stage7
